// File: rtl/clk_div_controller_if.sv
// Command/response stream bundle between the host interface and the divider
// control stage: one 32-bit command stream in, one 32-bit response stream out.
interface clk_div_controller_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;

  modport master (
    output cmd_valid, cmd_data, resp_ready,
    input  cmd_ready, resp_valid, resp_data
  );

  modport slave (
    input  cmd_valid, cmd_data, resp_ready,
    output cmd_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/clk_div_controller.sv
// Command-driven configuration stage for the clock divider: decodes host
// commands, sequences N-pulse single-step runs and returns one response each.
module clk_div_controller #(
  parameter int COUNTER_BITS       = 32,
  parameter int PULSE_CONTROL_BITS = 32,
  parameter int DEFAULT_DIVIDER    = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  clk_div_controller_if.slave           bus,
  output logic                          write_pulse,
  output logic                          option,
  output logic                          out_enable,
  output logic [COUNTER_BITS-1:0]       divider,
  output logic [PULSE_CONTROL_BITS-1:0] pulse,
  output logic                          busy
);

  localparam logic [3:0] OP_SET_DIV  = 4'h1;
  localparam logic [3:0] OP_RUN_AUTO = 4'h2;
  localparam logic [3:0] OP_STOP     = 4'h3;
  localparam logic [3:0] OP_STEP     = 4'h4;
  localparam logic [3:0] OP_STATUS   = 4'h5;

  localparam logic [3:0] ST_OK      = 4'h0;
  localparam logic [3:0] ST_BAD_OP  = 4'h1;
  localparam logic [3:0] ST_ABORTED = 4'h3;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STEP, S_RESP} state_t;

  state_t                        r_state, w_state_nxt;
  logic                          r_write_pulse, w_write_pulse_nxt;
  logic                          r_option, w_option_nxt;
  logic                          r_out_enable, w_out_enable_nxt;
  logic [COUNTER_BITS-1:0]       r_divider, w_divider_nxt;
  logic [PULSE_CONTROL_BITS-1:0] r_pulse, w_pulse_nxt;
  logic [PULSE_CONTROL_BITS-1:0] r_remaining, w_remaining_nxt;
  logic                          r_abort, w_abort_nxt;
  logic                          r_resp_valid, w_resp_valid_nxt;
  logic [31:0]                   r_resp_data, w_resp_data_nxt;

  logic                          w_cmd_ready;
  logic                          w_accept;
  logic                          w_busy;
  logic [3:0]                    w_op;
  logic [27:0]                   w_arg;
  logic [PULSE_CONTROL_BITS-1:0] w_step_n;
  logic [COUNTER_BITS-1:0]       w_div_arg;

  // The divider cannot divide by 0 or 1, so those ratios fall back to 2.
  function automatic logic [COUNTER_BITS-1:0] clamp_div(input logic [27:0] arg);
    logic [COUNTER_BITS-1:0] v;
    v = COUNTER_BITS'(arg);
    if (v < COUNTER_BITS'(2)) v = COUNTER_BITS'(2);
    return v;
  endfunction

  assign w_op        = bus.cmd_data[31:28];
  assign w_arg       = bus.cmd_data[27:0];
  assign w_step_n    = PULSE_CONTROL_BITS'(w_arg);
  assign w_div_arg   = clamp_div(w_arg);
  assign w_cmd_ready = (r_state == S_IDLE) || (r_state == S_STEP);
  assign w_accept    = bus.cmd_valid && w_cmd_ready;
  assign w_busy      = (r_state == S_LOAD) || (r_state == S_STEP);

  always_comb begin
    w_state_nxt       = r_state;
    w_write_pulse_nxt = 1'b0;
    w_option_nxt      = r_option;
    w_out_enable_nxt  = r_out_enable;
    w_divider_nxt     = r_divider;
    w_pulse_nxt       = r_pulse;
    w_remaining_nxt   = r_remaining;
    w_abort_nxt       = r_abort;
    w_resp_valid_nxt  = r_resp_valid;
    w_resp_data_nxt   = r_resp_data;

    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt      = S_RESP;
          w_resp_valid_nxt = 1'b1;
          w_resp_data_nxt  = {w_op, ST_OK, 24'h0};
          case (w_op)
            OP_SET_DIV: begin
              w_divider_nxt   = w_div_arg;
              w_resp_data_nxt = {w_op, ST_OK, 24'(w_div_arg)};
            end
            OP_RUN_AUTO: begin
              w_option_nxt     = 1'b1;
              w_out_enable_nxt = 1'b1;
            end
            OP_STOP: w_out_enable_nxt = 1'b0;
            OP_STATUS: begin
              w_resp_data_nxt = {w_op, ST_OK, 21'h0, r_option, r_out_enable, w_busy};
            end
            OP_STEP: begin
              // A zero-length run answers immediately without touching the divider.
              if (w_step_n != '0) begin
                w_state_nxt       = S_LOAD;
                w_resp_valid_nxt  = 1'b0;
                w_option_nxt      = 1'b0;
                w_out_enable_nxt  = 1'b0;
                w_pulse_nxt       = w_step_n;
                w_write_pulse_nxt = 1'b1;
                w_remaining_nxt   = w_step_n;
                w_abort_nxt       = 1'b0;
              end
            end
            default: w_resp_data_nxt = {w_op, ST_BAD_OP, 24'h0};
          endcase
        end
      end
      S_LOAD: begin
        if (r_abort) begin
          w_state_nxt      = S_RESP;
          w_abort_nxt      = 1'b0;
          w_resp_valid_nxt = 1'b1;
          w_resp_data_nxt  = {OP_STOP, ST_ABORTED, 24'(r_remaining)};
        end else begin
          w_state_nxt      = S_STEP;
          w_out_enable_nxt = 1'b1;
        end
      end
      S_STEP: begin
        // Only STOP interrupts a run; every other command is swallowed silently.
        if (w_accept && (w_op == OP_STOP)) begin
          w_state_nxt       = S_LOAD;
          w_out_enable_nxt  = 1'b0;
          w_write_pulse_nxt = 1'b1;
          w_pulse_nxt       = '0;
          w_abort_nxt       = 1'b1;
        end else if (r_remaining == PULSE_CONTROL_BITS'(1)) begin
          w_state_nxt      = S_RESP;
          w_out_enable_nxt = 1'b0;
          w_resp_valid_nxt = 1'b1;
          w_resp_data_nxt  = {OP_STEP, ST_OK, 24'(r_pulse)};
        end else begin
          w_remaining_nxt = r_remaining - PULSE_CONTROL_BITS'(1);
        end
      end
      S_RESP: begin
        if (bus.resp_ready) begin
          w_state_nxt      = S_IDLE;
          w_resp_valid_nxt = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_write_pulse <= 1'b0;
      r_option      <= 1'b0;
      r_out_enable  <= 1'b0;
      r_divider     <= COUNTER_BITS'(DEFAULT_DIVIDER);
      r_pulse       <= '0;
      r_remaining   <= '0;
      r_abort       <= 1'b0;
      r_resp_valid  <= 1'b0;
      r_resp_data   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_write_pulse <= w_write_pulse_nxt;
      r_option      <= w_option_nxt;
      r_out_enable  <= w_out_enable_nxt;
      r_divider     <= w_divider_nxt;
      r_pulse       <= w_pulse_nxt;
      r_remaining   <= w_remaining_nxt;
      r_abort       <= w_abort_nxt;
      r_resp_valid  <= w_resp_valid_nxt;
      r_resp_data   <= w_resp_data_nxt;
    end
  end

  assign bus.cmd_ready  = w_cmd_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_data  = r_resp_data;
  assign write_pulse    = r_write_pulse;
  assign option         = r_option;
  assign out_enable     = r_out_enable;
  assign divider        = r_divider;
  assign pulse          = r_pulse;
  assign busy           = w_busy;

endmodule

// File: tb/tb_clk_div_controller.sv
// Bench for clk_div_controller: a cycle-window model of each command's effect
// is compared against every DUT output each cycle, plus literal spot checks.
module tb_clk_div_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        write_pulse, option, out_enable, busy;
  logic [31:0] divider, pulse;

  clk_div_controller_if bus();

  clk_div_controller #(
    .COUNTER_BITS(32), .PULSE_CONTROL_BITS(32), .DEFAULT_DIVIDER(2)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .write_pulse(write_pulse), .option(option), .out_enable(out_enable),
    .divider(divider), .pulse(pulse), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  // Architectural model: settled register values plus cycle windows of a run.
  logic [31:0] m_div, m_pulse, m_resp_word;
  logic        m_opt, m_oe, m_resp_pending;
  int          m_oe_lo, m_oe_hi, m_busy_lo, m_busy_hi, m_wp_cyc, m_resp_cyc;

  logic [31:0] last_resp, last_wp_pulse;
  int          oe_cnt, wp_cnt;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_div = 32'd2; m_pulse = 32'd0; m_resp_word = 32'd0;
    m_opt = 1'b0; m_oe = 1'b0; m_resp_pending = 1'b0;
    m_oe_lo = 1; m_oe_hi = 0; m_busy_lo = 1; m_busy_hi = 0;
    m_wp_cyc = -1; m_resp_cyc = 0;
  endtask

  // Called right after the edge c at which word w was taken by the DUT.
  task automatic model_accept(input logic [31:0] w, input int c);
    logic [3:0]  op;
    logic [27:0] arg;
    logic [31:0] d, rem;
    int          n;
    op  = w[31:28];
    arg = w[27:0];
    n   = int'(arg);
    if ((c - 1) >= m_oe_lo && (c - 1) <= m_oe_hi) begin
      if (op == 4'h3) begin
        rem         = 32'(m_oe_hi - c + 2);
        m_oe_hi     = c - 1;
        m_wp_cyc    = c;
        m_pulse     = 32'd0;
        m_busy_hi   = c;
        m_resp_cyc  = c + 1;
        m_resp_word = {8'h33, rem[23:0]};
      end
    end else begin
      m_resp_pending = 1'b1;
      m_resp_cyc     = c;
      m_resp_word    = {op, 4'h0, 24'h0};
      case (op)
        4'h1: begin
          d = (n < 2) ? 32'd2 : 32'(arg);
          m_div = d;
          m_resp_word = {8'h10, d[23:0]};
        end
        4'h2: begin m_opt = 1'b1; m_oe = 1'b1; end
        4'h3: m_oe = 1'b0;
        4'h5: m_resp_word = {8'h50, 21'h0, m_opt, m_oe, 1'b0};
        4'h4: begin
          if (n != 0) begin
            m_opt = 1'b0; m_oe = 1'b0; m_pulse = 32'(arg);
            m_wp_cyc  = c;
            m_oe_lo   = c + 1; m_oe_hi   = c + n;
            m_busy_lo = c;     m_busy_hi = c + n;
            m_resp_cyc  = c + n + 1;
            m_resp_word = {8'h40, arg[23:0]};
          end
        end
        default: m_resp_word = {op, 4'h1, 24'h0};
      endcase
    end
  endtask

  always @(negedge clk) begin
    logic exp_busy, exp_wp, exp_oe, exp_rv, exp_cr;
    if (!reset && chk_en) begin
      exp_busy = (cyc >= m_busy_lo) && (cyc <= m_busy_hi);
      exp_wp   = (cyc == m_wp_cyc);
      exp_oe   = ((cyc >= m_oe_lo) && (cyc <= m_oe_hi)) ? 1'b1 : m_oe;
      exp_rv   = m_resp_pending && (cyc >= m_resp_cyc);
      exp_cr   = !exp_rv && !exp_wp;
      check("write_pulse", 32'(write_pulse), 32'(exp_wp));
      check("pulse", pulse, m_pulse);
      check("option", 32'(option), 32'(m_opt));
      check("out_enable", 32'(out_enable), 32'(exp_oe));
      check("divider", divider, m_div);
      check("busy", 32'(busy), 32'(exp_busy));
      check("cmd_ready", 32'(bus.cmd_ready), 32'(exp_cr));
      check("resp_valid", 32'(bus.resp_valid), 32'(exp_rv));
      if (exp_rv) check("resp_data", bus.resp_data, m_resp_word);
      if (out_enable) oe_cnt++;
      if (write_pulse) begin wp_cnt++; last_wp_pulse = pulse; end
      if (exp_rv && bus.resp_ready) begin
        last_resp = bus.resp_data;
        m_resp_pending = 1'b0;
      end
    end
  end

  task automatic send(input logic [31:0] w);
    logic rdy;
    bit   ok;
    ok = 1'b0;
    bus.cmd_data  = w;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk); rdy = bus.cmd_ready;
      @(posedge clk); #1;
      if (rdy) ok = 1'b1;
    end
    bus.cmd_valid = 1'b0;
    if (ok) model_accept(w, cyc);
    else check("cmd_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_resp();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(posedge clk);
      if (!m_resp_pending) done = 1'b1;
    end
    #1;
    if (!done) check("resp_timeout", 32'd0, 32'd1);
  endtask

  task automatic ticks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_data = 32'h0; bus.resp_ready = 1'b1;
    last_resp = 32'h0; last_wp_pulse = 32'h0; oe_cnt = 0; wp_cnt = 0;
    model_reset();
    ticks(3);
    reset = 1'b0;
    chk_en = 1'b1;
    check("rst_divider", divider, 32'd2);
    check("rst_option", 32'(option), 32'd0);
    check("rst_out_enable", 32'(out_enable), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    send(32'h5000_0000); wait_resp();
    check("status_resp", last_resp, 32'h5000_0000);

    send(32'h1000_0000); wait_resp();
    check("setdiv0_resp", last_resp, 32'h1000_0002);
    check("setdiv0_div", divider, 32'd2);
    send(32'h1000_000A); wait_resp();
    check("setdiv10_resp", last_resp, 32'h1000_000A);
    check("setdiv10_div", divider, 32'd10);

    oe_cnt = 0; wp_cnt = 0;
    send(32'h4000_0003); wait_resp();
    check("step3_resp", last_resp, 32'h4000_0003);
    check("step3_oe_cycles", 32'(oe_cnt), 32'd3);
    check("step3_wp_count", 32'(wp_cnt), 32'd1);
    check("step3_wp_pulse", last_wp_pulse, 32'd3);

    oe_cnt = 0; wp_cnt = 0;
    send(32'h4000_0000); wait_resp();
    check("step0_resp", last_resp, 32'h4000_0000);
    check("step0_wp_count", 32'(wp_cnt), 32'd0);
    check("step0_oe_cycles", 32'(oe_cnt), 32'd0);

    // STATUS mid-run is swallowed; STOP lands in the 41st STEP cycle.
    oe_cnt = 0; wp_cnt = 0;
    send(32'h4000_0064);
    ticks(10);
    send(32'h5000_0000);
    ticks(30);
    send(32'h3000_0000);
    wait_resp();
    check("abort_resp", last_resp, 32'h3300_003C);
    check("abort_oe_cycles", 32'(oe_cnt), 32'd41);
    check("abort_wp_count", 32'(wp_cnt), 32'd2);
    check("abort_wp_pulse", last_wp_pulse, 32'd0);
    check("abort_oe_after", 32'(out_enable), 32'd0);

    send(32'h2000_0000); wait_resp();
    check("auto_resp", last_resp, 32'h2000_0000);
    check("auto_option", 32'(option), 32'd1);
    check("auto_oe", 32'(out_enable), 32'd1);

    bus.resp_ready = 1'b0;
    send(32'hF000_0000);
    ticks(5);
    check("badop_hold_data", bus.resp_data, 32'hF100_0000);
    check("badop_hold_ready", 32'(bus.cmd_ready), 32'd0);
    check("badop_hold_option", 32'(option), 32'd1);
    check("badop_hold_oe", 32'(out_enable), 32'd1);
    bus.resp_ready = 1'b1;
    wait_resp();
    check("badop_resp", last_resp, 32'hF100_0000);

    send(32'h4000_0002); wait_resp();
    check("step_in_auto_resp", last_resp, 32'h4000_0002);
    check("step_in_auto_option", 32'(option), 32'd0);
    check("step_in_auto_oe", 32'(out_enable), 32'd0);

    send(32'h1000_0007); wait_resp();
    send(32'h4000_0014);
    ticks(5);
    reset = 1'b1;
    ticks(1);
    model_reset();
    ticks(1);
    reset = 1'b0;
    check("midrst_divider", divider, 32'd2);
    check("midrst_oe", 32'(out_enable), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("midrst_pulse", pulse, 32'd0);
    ticks(25);

    send(32'h5000_0000); wait_resp();
    check("final_status", last_resp, 32'h5000_0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
